// File: rtl/serial_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl_pkg
// Shared definitions for the serial frame controller:
//   - state_t   : frame FSM states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   - DEF_WIDTH : default bits per frame
//   - DEF_HALF  : default system clocks per serial-clock half period
//   - clog2()   : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package serial_frame_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_HALF  = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // clog2(1) = 0, clog2(2) = 1, clog2(16) = 4, clog2(17) = 5
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_ctrl_shifter.sv
// -----------------------------------------------------------------------------
// frame_shifter
// WIDTH-bit parallel-load, shift-left register. A zero is shifted in at the
// LSB, so once every payload bit has been shifted past the MSB the register is
// all zero and msb rests low between frames.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset (clears the register)
//   load  : capture din (takes priority over shift)
//   shift : move left one place
//   din   : parallel word
//   msb   : current most significant bit (flop output)
// -----------------------------------------------------------------------------
module frame_shifter
  import serial_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = r_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl
// Round-robin arbiter and chip-select-framed serializer for two requesters.
// A granted word is sent MSB first: SETUP (HALF cycles, cs_n low), WIDTH bit
// periods of 2*HALF cycles (sclk low then high), HOLD (HALF cycles), then GAP
// (HALF cycles, cs_n high) before returning to IDLE.
// Ports:
//   clk, reset        : system clock, asynchronous active-low reset
//   req0/data0/ack0   : requester 0 handshake (ack0 is a 1-cycle pulse)
//   req1/data1/ack1   : requester 1 handshake (ack1 is a 1-cycle pulse)
//   cs_n, sclk, sdo   : serial bus (sclk idles low, sdo MSB first)
//   busy              : high whenever the FSM is not in IDLE
//   grant_id          : requester owning the current or last frame
// -----------------------------------------------------------------------------
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HALF  = DEF_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             cs_n,
  output logic             sclk,
  output logic             sdo,
  output logic             busy,
  output logic             grant_id
);

  localparam int DIV_W = (clog2(HALF) < 1) ? 1 : clog2(HALF);
  localparam int BIT_W = clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_t           r_state;
  logic             r_last;
  logic             r_grant;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_cs_n;
  logic             r_sclk;
  logic             r_busy;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;

  logic             w_any_req;
  logic             w_pick;
  logic             w_load;
  logic             w_shift;
  logic             w_div_done;
  logic             w_msb;
  logic [WIDTH-1:0] w_din;

  // With both requests up, the requester not served last wins; otherwise the
  // single active requester wins (w_pick = 1 selects requester 1).
  assign w_any_req  = req0 | req1;
  assign w_pick     = (req0 & req1) ? ~r_last : req1;
  assign w_din      = w_pick ? data1 : data0;
  assign w_div_done = (r_div == '0);
  assign w_load     = (r_state == IDLE) & w_any_req;
  // Shift on every sclk falling edge, including the one after the last bit:
  // that final shift empties the register so sdo is low in HOLD and beyond.
  assign w_shift    = (r_state == SHIFT) & r_sclk & w_div_done;

  frame_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .msb   (w_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_ack0  <= ~w_pick;
            r_ack1  <= w_pick;
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= DIV_LOAD;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_div_done) begin
            r_div   <= DIV_LOAD;
            r_bit   <= BIT_LOAD;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div - DIV_ONE;
          end
        end
        SHIFT: begin
          if (!w_div_done) begin
            r_div <= r_div - DIV_ONE;
          end else begin
            r_div <= DIV_LOAD;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == '0) begin
                r_state <= HOLD;
              end else begin
                r_bit <= r_bit - BIT_ONE;
              end
            end
          end
        end
        HOLD: begin
          if (w_div_done) begin
            r_div   <= DIV_LOAD;
            r_cs_n  <= 1'b1;
            r_state <= GAP;
          end else begin
            r_div <= r_div - DIV_ONE;
          end
        end
        GAP: begin
          if (w_div_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_div <= r_div - DIV_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign cs_n     = r_cs_n;
  assign sclk     = r_sclk;
  assign sdo      = w_msb;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
module tb_serial_frame_ctrl;

  localparam int W      = 16;
  localparam int H      = 2;
  localparam int FRAME  = H + 2 * H * W + 2 * H;  // ack to IDLE
  localparam int CS_LO  = H * (2 * W + 2);

  typedef struct {
    bit           id;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_v;
  logic [W-1:0] dat [2];
  logic         ack0, ack1, cs_n, sclk, sdo, busy, grant_id;

  logic         s_req0, s_req1;
  logic [7:0]   s_dat0, s_dat1;
  logic         s_ack0, s_ack1, s_cs_n, s_sclk, s_sdo, s_busy, s_gid;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   idle_at = 0;
  bit   last    = 1'b1;
  exp_t q[$];

  always #5 clk = ~clk;

  serial_frame_ctrl #(.WIDTH(W), .HALF(H)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .data0(dat[0]), .ack0(ack0),
    .req1(req_v[1]), .data1(dat[1]), .ack1(ack1),
    .cs_n(cs_n), .sclk(sclk), .sdo(sdo), .busy(busy), .grant_id(grant_id)
  );

  serial_frame_ctrl #(.WIDTH(8), .HALF(1)) u_small (
    .clk(clk), .reset(reset),
    .req0(s_req0), .data0(s_dat0), .ack0(s_ack0),
    .req1(s_req1), .data1(s_dat1), .ack1(s_ack1),
    .cs_n(s_cs_n), .sclk(s_sclk), .sdo(s_sdo), .busy(s_busy), .grant_id(s_gid)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom);
  endfunction

  // Reference model: one frame occupies the link for FRAME cycles after its
  // grant; the next grant is possible on the edge after IDLE is reached.
  // Contention goes to whoever was not served last; reset restores last = 1.
  task automatic model_proc();
    bit pick;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        last    = 1'b1;
        idle_at = cyc + 1;
      end else if (cyc >= idle_at && req_v != 2'b00) begin
        pick = (req_v == 2'b11) ? ~last : req_v[1];
        q.push_back('{pick, dat[pick], cyc});
        last    = pick;
        idle_at = cyc + FRAME + 1;
      end
    end
  endtask

  task automatic monitor_proc();
    exp_t         e;
    int           hi_run, nb, cs_lo, bz, extra, bad, g;
    bit           ps, pd, aborted;
    logic [W-1:0] bits;
    hi_run = 0;
    forever begin
      @(negedge clk);
      if (reset && (ack0 || ack1)) begin
        chk("ack_onehot", ack0 & ack1, 0);
        chk("deselect_gap", hi_run >= H + 1, 1);
        chk("ack_expected", q.size() != 0, 1);
        hi_run = 0;
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ack_id", ack1, e.id);
          chk("grant_id", grant_id, e.id);
          chk("ack_cycle", cyc, e.cyc);
          bits = '0; nb = 0; cs_lo = 0; bz = 0; extra = 0; bad = 0; g = 0;
          ps = 1'b0; pd = sdo; aborted = 1'b0;
          forever begin
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            bz    += busy;
            cs_lo += !cs_n;
            hi_run = cs_n ? hi_run + 1 : 0;
            if (sclk && !ps) begin
              bits = {bits[W-2:0], sdo};
              nb++;
            end
            if (sclk && ps && (sdo != pd)) bad++;
            ps = sclk;
            pd = sdo;
            if (!busy || g >= 300) break;
            @(negedge clk);
            g++;
            if (ack0 || ack1) extra++;
          end
          if (!aborted) begin
            chk("frame_bits", bits, e.data);
            chk("bit_count", nb, W);
            chk("cs_low_cycles", cs_lo, CS_LO);
            chk("busy_cycles", bz, FRAME);
            chk("extra_ack", extra, 0);
            chk("sdo_stable_sclk_hi", bad, 0);
          end
        end
      end else begin
        hi_run = cs_n ? hi_run + 1 : 0;
      end
    end
  endtask

  task automatic wait_ack(input int id, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      if ((id == 0) ? ack0 : ack1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_within_bound", ok, 1);
  endtask

  task automatic send(input int id, input logic [W-1:0] d, input bit keep);
    bit ok;
    dat[id]   = d;
    req_v[id] = 1'b1;
    wait_ack(id, ok);
    if (!keep) req_v[id] = 1'b0;
  endtask

  task automatic rand_drive(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      send(id, rnd_word(), 1'($urandom_range(0, 1)));
    end
    req_v[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 400);
    chk("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_frame();
    bit ok;
    int nr, t, na;
    bit ps;
    dat[0]   = 16'hFFFF;
    req_v[0] = 1'b1;
    wait_ack(0, ok);
    req_v[0] = 1'b0;
    dat[1]   = rnd_word();
    req_v[1] = 1'b1;
    nr = 0; t = 0; ps = sclk;
    while (nr < 9 && t < 200) begin
      @(negedge clk);
      t++;
      if (sclk && !ps) nr++;
      ps = sclk;
    end
    chk("reached_bit7", nr, 9);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_cs_n", cs_n, 1);
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_sdo", sdo, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_acks", {ack0, ack1}, 0);
    na = 0;
    repeat (4) begin
      @(negedge clk);
      na += int'(ack0 | ack1);
    end
    chk("ack_during_reset", na, 0);
    reset = 1'b1;
    wait_ack(1, ok);
    req_v[1] = 1'b0;
  endtask

  task automatic small_test();
    int t, bz, cl, nr, r1, r2;
    logic [7:0] sb;
    bit ps;
    t = 0; bz = 0; cl = 0; nr = 0; r1 = 0; r2 = 0; sb = '0; ps = 1'b0;
    s_dat0 = 8'h96;
    s_req0 = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ack0 && t < 50);
    chk("small_ack", s_ack0, 1);
    s_req0 = 1'b0;
    chk("small_grant_id", s_gid, 0);
    t = 0;
    while (s_busy && t < 100) begin
      bz++;
      if (!s_cs_n) cl++;
      if (s_sclk && !ps) begin
        sb = {sb[6:0], s_sdo};
        nr++;
        if (nr == 1) r1 = t;
        if (nr == 2) r2 = t;
      end
      ps = s_sclk;
      @(negedge clk);
      t++;
    end
    chk("small_busy_cycles", bz, 19);
    chk("small_cs_low", cl, 18);
    chk("small_bits", sb, 8'h96);
    chk("small_nbits", nr, 8);
    chk("small_sclk_period", r2 - r1, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    req_v  = 2'b00;
    dat[0] = '0;
    dat[1] = '0;
    s_req0 = 1'b0; s_req1 = 1'b0; s_dat0 = '0; s_dat1 = '0;
    fork
      model_proc();
      monitor_proc();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_sdo", sdo, 0);
    chk("reset_acks", {ack0, ack1}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Contention straight out of reset: requester 0 first, then 1.
    fork
      send(0, 16'h0001, 1'b0);
      send(1, 16'h8000, 1'b0);
    join
    wait_idle();

    // Both held for four frames.
    fork
      begin send(0, rnd_word(), 1'b1); send(0, rnd_word(), 1'b0); end
      begin send(1, rnd_word(), 1'b1); send(1, rnd_word(), 1'b0); end
    join
    wait_idle();

    // Single transfer.
    send(0, 16'hA5C3, 1'b0);
    wait_idle();

    // Late request arriving during SHIFT.
    fork
      send(0, rnd_word(), 1'b0);
      begin repeat (20) @(negedge clk); send(1, rnd_word(), 1'b0); end
    join
    wait_idle();

    // Randomized traffic on both requesters.
    fork
      rand_drive(0, 8);
      rand_drive(1, 8);
    join
    wait_idle();

    reset_mid_frame();
    wait_idle();
    chk("queue_drained", q.size(), 0);

    small_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Frame controller and arbiter for the ADC/DAC serial test link. It accepts 16-bit parallel words from two requesters over a req/ack handshake and arbitrates between them round-robin. It shifts the granted word out MSB-first on a chip-select-framed serial bus with a generated serial clock. It replaces free-running counter-plus-mux serialization with a framed, arbitrated, rate-controlled transfer.

## Interface
Parameters:
- WIDTH, 16, bits per frame; WIDTH >= 2
- HALF, 2, system clocks per serial-clock half period; HALF >= 1

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; the block is held in reset while reset = 0
- req0  input  1  requester 0 wants a frame; held until ack0
- data0  input  WIDTH  requester 0 word; stable while req0 = 1
- ack0  output  1  one-cycle pulse: data0 captured
- req1  input  1  requester 1 wants a frame; held until ack1
- data1  input  WIDTH  requester 1 word; stable while req1 = 1
- ack1  output  1  one-cycle pulse: data1 captured
- cs_n  output  1  frame select, active low
- sclk  output  1  serial clock, idles low
- sdo  output  1  serial data, MSB first; changes only while sclk = 0
- busy  output  1  high in every state except IDLE
- grant_id  output  1  requester owning the current or last frame

## Operation
- All outputs are registered.
- Reset values: cs_n = 1, sclk = 0, sdo = 0, ack0 = ack1 = 0, busy = 0, grant_id = 0, state = IDLE.
- The last-served pointer resets to 1, so req0 wins the first contention.
- IDLE
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester that was not served last.
  - On grant: load the shift register with that requester's data, pulse its ack, set grant_id, update the last-served pointer, and go to SETUP.
- SETUP: cs_n = 0, sclk = 0, sdo = shift register MSB. Lasts HALF cycles, then go to SHIFT.
- SHIFT: WIDTH bit periods of 2*HALF cycles each.
  - Each period is sclk = 0 for HALF cycles, then sclk = 1 for HALF cycles.
  - The shift register moves left one place on each sclk falling edge, and the new MSB appears on sdo in the same cycle.
  - After the high half of the last bit, go to HOLD.
- HOLD: cs_n = 0, sclk = 0, sdo = 0. Lasts HALF cycles, then go to GAP.
- GAP: cs_n = 1. Lasts HALF cycles to guarantee minimum deselect time, then go to IDLE.
- Requests are ignored outside IDLE and stay pending; there is no queueing beyond the held req.
- A requester that keeps req high after its ack is issuing a new request. Round-robin still applies to it.
- Counters:
  - Divider counter is clog2(HALF) bits wide (minimum 1) and reloads at every phase change.
  - Bit counter is clog2(WIDTH) bits wide and counts WIDTH-1 down to 0.
  - Both counters stop at their terminal values; neither wraps within a frame.

## Timing
- Request to ack: 1 cycle. req is sampled at edge N in IDLE; ack and cs_n = 0 are high from edge N to N+1.
- Frame length from ack to return to IDLE: HALF + 2*HALF*WIDTH + 2*HALF cycles. With the defaults this is 70 cycles.
- cs_n is low for HALF*(2*WIDTH + 2) cycles.
- Bit k (MSB = WIDTH-1) is valid from HALF cycles before the corresponding sclk rise until the next fall.
- Minimum idle time between frames is HALF cycles of GAP plus 1 IDLE cycle.
- Simultaneous requests: exactly one ack. The other request waits for the next IDLE.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. The partial frame is abandoned with no further ack. After release, pending requests are arbitrated as from power-up, so req0 wins.
- A request arriving on the same edge that reset is released is not granted until the next edge.

## Structure
- Shared package holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - the default WIDTH and HALF constants
  - a clog2 helper function
- One sub-module, frame_shifter: a WIDTH-bit load/shift-left register with inputs load, shift, and din, and output msb.
- Arbitration, counters and the FSM stay in serial_frame_ctrl.

## Test plan
- Single transfer: req0 with data0 = 16'hA5C3. Expect one ack0 pulse. Bits sampled at sclk rising edges read 1010_0101_1100_0011. cs_n is low for 68 cycles and busy is high for 70.
- Contention: req0 and req1 asserted in the same cycle with 16'h0001 and 16'h8000. Expect the req0 frame first (grant_id = 0), then the req1 frame (grant_id = 1), separated by at least 3 cycles with cs_n = 1.
- Fairness: both requests held continuously for 4 frames. Expect grants in the order 0, 1, 0, 1, and exactly one ack per frame.
- Late request: req1 asserted during SHIFT of a req0 frame. Expect no ack1 until the frame ends, then ack1 exactly 1 cycle after IDLE is reached.
- Reset mid-frame: reset driven low at bit 7 of a 16'hFFFF frame. Expect cs_n = 1, sclk = 0, sdo = 0 immediately with no further acks. After release with req1 held, expect a full req1 frame.
- HALF = 1, WIDTH = 8: data 8'h96. Expect an sclk period of 2 cycles, a frame of 19 cycles, and serial bits 1001_0110.
